// File: rtl/lifo_pkg.sv
// Shared definitions for the parametrised LIFO: operation encoding and count sizing.
package lifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } op_e;

  // Count must hold 0..DEPTH inclusive, so one bit more than the address.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lifo_ram.sv
// Storage for every LIFO entry below the top: synchronous write, asynchronous read, no reset.
module lifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata
);

  // The top entry lives in a register in the parent, so only DEPTH-1 slots are needed.
  logic [WIDTH-1:0] r_mem [0:DEPTH-2];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lifo_param.sv
// Parametrised LIFO with registered top-of-stack, occupancy flags, replace-top and error reporting.
// Define LIFO_ERR_STICKY_EN to make overflow/underflow sticky until reset.
module lifo_param
  import lifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            data_in,
  output logic [WIDTH-1:0]            data_out,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] r_top;
  logic [CW-1:0]    r_count;
  logic             r_empty, r_full, r_ae, r_af, r_ovf, r_unf;

  op_e              w_op;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] w_top_next;
  logic [CW-1:0]    w_cnt_m1, w_cnt_m2;
  logic [AW-1:0]    w_waddr, w_raddr;
  logic             w_we, w_ovf_evt, w_unf_evt;
  logic [WIDTH-1:0] w_rdata;

  assign w_cnt_m1 = r_count - CW'(1);
  assign w_cnt_m2 = r_count - CW'(2);
  assign w_waddr  = w_cnt_m1[AW-1:0];
  // Clamp keeps the read index inside storage when fewer than two entries exist.
  assign w_raddr  = (r_count > CW'(1)) ? w_cnt_m2[AW-1:0] : '0;
  assign w_we     = (w_op == OP_PUSH) && (r_count != '0);

  assign w_ovf_evt = push && r_full && !pop;
  assign w_unf_evt = pop && r_empty;

  always_comb begin
    w_op = OP_IDLE;
    if (push && pop && !r_empty)       w_op = OP_REPLACE;
    else if (push && !r_full)          w_op = OP_PUSH;
    else if (pop && !r_empty && !push) w_op = OP_POP;
  end

  always_comb begin
    w_cnt_next = r_count;
    w_top_next = r_top;
    case (w_op)
      OP_REPLACE: w_top_next = data_in;
      OP_PUSH: begin
        w_top_next = data_in;
        w_cnt_next = r_count + CW'(1);
      end
      OP_POP: begin
        w_top_next = (r_count > CW'(1)) ? w_rdata : '0;
        w_cnt_next = w_cnt_m1;
      end
      default: ;
    endcase
  end

  lifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_raddr (w_raddr),
    .i_wdata (r_top),
    .o_rdata (w_rdata)
  );

  // Flags derive from the next-state count so they always agree with count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_top   <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ae    <= 1'b1;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_top   <= w_top_next;
      r_count <= w_cnt_next;
      r_empty <= (w_cnt_next == '0);
      r_full  <= (w_cnt_next == DEPTH_C);
      r_ae    <= (w_cnt_next <= AE_C);
      r_af    <= (w_cnt_next >= AF_C);
`ifdef LIFO_ERR_STICKY_EN
      r_ovf   <= r_ovf | w_ovf_evt;
      r_unf   <= r_unf | w_unf_evt;
`else
      r_ovf   <= w_ovf_evt;
      r_unf   <= w_unf_evt;
`endif
    end
  end

  assign data_out     = r_top;
  assign count        = r_count;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_ae;
  assign almost_full  = r_af;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_lifo_param.sv
// Directed self-checking bench for lifo_param (DEPTH=4, AF_LEVEL=3, WIDTH=8).
module tb_lifo_param;

  localparam int W = 8;
  localparam int D = 4;
`ifdef LIFO_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, push, pop;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic [2:0]   count;
  logic         empty, full, almost_empty, almost_full, overflow, underflow;

  int assertCount = 0;
  int failCount   = 0;

  logic [W-1:0] mStack [0:D-1];
  int           mCnt;

  lifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(3), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .count(count), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic iRst, input logic iPush, input logic iPop, input logic [W-1:0] d);
    @(negedge clk);
    rst = iRst; push = iPush; pop = iPop; data_in = d;
    @(posedge clk);
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic checkState(input string tag, input logic [W-1:0] d, input int c);
    checkOutput({tag, " data"}, 32'(data_out), 32'(d));
    checkOutput({tag, " count"}, 32'(count), 32'(c));
    checkOutput({tag, " empty"}, 32'(empty), 32'(c == 0));
    checkOutput({tag, " full"}, 32'(full), 32'(c == D));
    checkOutput({tag, " aempty"}, 32'(almost_empty), 32'(c <= 2));
    checkOutput({tag, " afull"}, 32'(almost_full), 32'(c >= 3));
  endtask

  initial begin
    logic [W-1:0] pushVals [0:3];
    logic [W-1:0] popExp   [0:3];
    logic [W-1:0] d;
    logic         p;
    logic         expTop;
    pushVals = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    popExp   = '{8'hA3, 8'hA2, 8'hA1, 8'h00};
    rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;

    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkState("reset", 8'h00, 0);
    checkOutput("reset ovf", 32'(overflow), 32'd0);
    checkOutput("reset unf", 32'(underflow), 32'd0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, pushVals[i]);
      checkState($sformatf("push%0d", i), pushVals[i], i + 1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5);
    checkState("ovfpush", 8'hA4, 4);
    checkOutput("ovf pulse", 32'(overflow), 32'd1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
      checkState($sformatf("pop%0d", i), popExp[i], 3 - i);
      checkOutput($sformatf("pop%0d ovf", i), 32'(overflow), 32'(STICKY));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkState("unfpop", 8'h00, 0);
    checkOutput("unf pulse", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("unf after", 32'(underflow), 32'(STICKY));
    checkOutput("ovf after", 32'(overflow), 32'(STICKY));

    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("clr ovf", 32'(overflow), 32'd0);
    checkOutput("clr unf", 32'(underflow), 32'd0);

    // Replace while partially filled must not disturb the entry underneath.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h11);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h33);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h22);
    checkState("repl part", 8'h22, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkState("repl pop", 8'h11, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h44);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h55);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h66);
    checkState("refill", 8'h66, 4);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h77);
    checkState("repl full", 8'h77, 4);
    checkOutput("repl full ovf", 32'(overflow), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkState("repl full pop", 8'h55, 3);

    mStack[0] = 8'h11; mStack[1] = 8'h44; mStack[2] = 8'h55; mStack[3] = 8'h00;
    mCnt = 3;
    for (int i = 0; i < 64; i++) begin
      p = (i % 2 == 0);
      d = 8'($urandom_range(0, 255));
      applyStimulus(1'b0, p, !p, d);
      if (p && mCnt < D) begin
        mStack[mCnt] = d;
        mCnt++;
      end else if (!p && mCnt > 0) begin
        mCnt--;
      end
      checkOutput($sformatf("alt%0d data", i), 32'(data_out),
                  (mCnt > 0) ? 32'(mStack[mCnt-1]) : 32'd0);
      checkOutput($sformatf("alt%0d count", i), 32'(count), 32'(mCnt));
    end

    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h5B);
    checkState("pre rst", 8'h5B, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5C);
    checkState("rst push", 8'h00, 0);
    expTop = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C);
    checkState("post rst", 8'h3C, 1);
    checkOutput("post rst ovf", 32'(overflow), 32'(expTop));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
